// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code decoder.
// Synchronizes the raw PS/2 lines, frames 11-bit packets on the keyboard
// clock's falling edges, and turns the byte stream (with E0/F0 prefixes)
// into make/break pulses plus a held key code.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       iCLK,
   input  logic       iRST_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_en,
   output logic       key_rel,
   output logic       key_ext,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // synchronizer and edge-detect flops
   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q;

   // frame FSM state
   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_d;
   logic          byte_vld_q, byte_vld_d;
   logic [7:0]    byte_q;

   // decoder state and outputs
   logic       ext_q, ext_d;
   logic       brk_q, brk_d;
   logic [7:0] code_q, code_d;
   logic       en_q, en_d;
   logic       rel_q, rel_d;
   logic       kext_q, kext_d;
   logic       ferr_q;

   logic fall;
   logic bit_s;

   // Idle bus is high, so the synchronizers reset to 1 to avoid a fake edge.
   assign fall  = clk_prev_q & ~clk_s2_q;
   assign bit_s = dat_s2_q;

   // Two-flop synchronizers plus one delayed copy of the clock for edges.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
      end
   end

   // Frame FSM and datapath registers.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q    <= IDLE;
         shift_q    <= 8'h00;
         cnt_q      <= 3'd0;
         par_ok_q   <= 1'b0;
         tmo_q      <= '0;
         byte_vld_q <= 1'b0;
         byte_q     <= 8'h00;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         par_ok_q   <= par_ok_d;
         tmo_q      <= tmo_d;
         byte_vld_q <= byte_vld_d;
         ferr_q     <= err_d;
         if (byte_vld_d) byte_q <= shift_q;
      end
   end

   // Frame next-state: advance on falling edges only; abort if the
   // keyboard clock stalls mid-frame.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      par_ok_d   = par_ok_q;
      tmo_d      = tmo_q;
      err_d      = 1'b0;
      byte_vld_d = 1'b0;

      if (state_q != IDLE) begin
         if (fall) tmo_d = '0;
         else      tmo_d = tmo_q + TW'(1);
      end

      case (state_q)
         IDLE: begin
            tmo_d = '0;
            // a high sample here is a glitch, not a start bit
            if (fall && !bit_s) begin
               state_d = DATA;
               cnt_d   = 3'd0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_d = {bit_s, shift_q[7:1]};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_ok_d = ^{shift_q, bit_s};
               state_d  = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               if (bit_s && par_ok_q) byte_vld_d = 1'b1;
               else                   err_d      = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES)) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
         tmo_d   = '0;
         err_d   = 1'b1;
      end
   end

   // Scan-code decode: prefixes only set flags, other bytes emit a pulse.
   always_comb begin
      code_d = code_q;
      kext_d = kext_q;
      en_d   = 1'b0;
      rel_d  = 1'b0;
      ext_d  = ext_q;
      brk_d  = brk_q;

      if (byte_vld_q) begin
         if (byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            code_d = byte_q;
            kext_d = ext_q;
            if (brk_q) rel_d = 1'b1;
            else       en_d  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end

      // a broken frame may have been the tail of a prefix sequence
      if (err_d) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
   end

   // Decoder registers.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         code_q <= 8'h00;
         kext_q <= 1'b0;
         en_q   <= 1'b0;
         rel_q  <= 1'b0;
         ext_q  <= 1'b0;
         brk_q  <= 1'b0;
      end else begin
         code_q <= code_d;
         kext_q <= kext_d;
         en_q   <= en_d;
         rel_q  <= rel_d;
         ext_q  <= ext_d;
         brk_q  <= brk_d;
      end
   end

   assign key_code  = code_q;
   assign key_en    = en_q;
   assign key_rel   = rel_q;
   assign key_ext   = kext_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: tasks drive PS/2 frames and push
// expected events; a monitor pops and compares on every output pulse.
module tb_ps2_key_decoder;

   localparam int TO   = 200;
   localparam int HALF = 20;

   localparam int K_MAKE = 0;
   localparam int K_REL  = 1;
   localparam int K_ERR  = 2;

   logic       iCLK = 1'b0;
   logic       iRST_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key_code;
   logic       key_en, key_rel, key_ext, frame_err;

   typedef struct {
      int         kind;
      logic [7:0] code;
      logic       ext;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   kind;
   int   checks = 0;
   int   failures = 0;
   logic prev_en = 1'b0, prev_rel = 1'b0, prev_err = 1'b0;
   logic [7:0] exp_code = 8'h00;
   logic       exp_ext = 1'b0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_code(key_code), .key_en(key_en), .key_rel(key_rel),
      .key_ext(key_ext), .frame_err(frame_err)
   );

   always #5 iCLK = ~iCLK;

   // monitor: every pulse must match the head of the scoreboard
   always @(negedge iCLK) begin
      if (iRST_n) begin
         if (key_en || key_rel || frame_err) begin
            checks++;
            kind = frame_err ? K_ERR : (key_rel ? K_REL : K_MAKE);
            if ((key_en && key_rel) || (frame_err && (key_en || key_rel))) begin
               failures++;
               $display("FAIL pulse_overlap: en=%b rel=%b err=%b, required one at a time",
                        key_en, key_rel, frame_err);
            end else if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pulse: kind=%0d code=%02h ext=%b, required no pulse",
                        kind, key_code, key_ext);
            end else begin
               e = q.pop_front();
               if (kind !== e.kind || key_code !== e.code || key_ext !== e.ext) begin
                  failures++;
                  $display("FAIL event: got kind=%0d code=%02h ext=%b, required kind=%0d code=%02h ext=%b",
                           kind, key_code, key_ext, e.kind, e.code, e.ext);
               end
            end
            if ((key_en && prev_en) || (key_rel && prev_rel) || (frame_err && prev_err)) begin
               failures++;
               $display("FAIL pulse_width: en=%b rel=%b err=%b high two cycles, required 1 cycle",
                        key_en, key_rel, frame_err);
            end
         end
         prev_en  = key_en;
         prev_rel = key_rel;
         prev_err = frame_err;
      end else begin
         prev_en  = 1'b0;
         prev_rel = 1'b0;
         prev_err = 1'b0;
      end
   end

   task automatic push(input int k, input logic [7:0] c, input logic x);
      exp_t t;
      t.kind = k; t.code = c; t.ext = x;
      q.push_back(t);
      exp_code = c;
      exp_ext  = x;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(posedge iCLK);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge iCLK);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(stop);
      ps2_data = 1'b1;
      repeat (HALF) @(posedge iCLK);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge iCLK);
      repeat (5) @(posedge iCLK);
   endtask

   task automatic test_reset();
      iRST_n = 1'b0;
      repeat (3) @(negedge iCLK);
      checks++;
      if ({key_code, key_en, key_rel, key_ext, frame_err} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs: got %03h, required 000",
                  {key_code, key_en, key_rel, key_ext, frame_err});
      end
      iRST_n = 1'b1;
      repeat (5) @(posedge iCLK);
   endtask

   task automatic test_make();
      push(K_MAKE, 8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1);
      // typematic repeat must pulse again
      push(K_MAKE, 8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1);
      drain();
      checks++;
      if (q.size() !== 0) begin
         failures++;
         $display("FAIL make_drain: %0d events pending, required 0", q.size());
      end
   endtask

   task automatic test_break();
      send_frame(8'hF0, 1'b0, 1'b1);
      push(K_REL, 8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1);
      push(K_MAKE, 8'h72, 1'b0);
      send_frame(8'h72, 1'b0, 1'b1);
      drain();
      checks++;
      if (q.size() !== 0) begin
         failures++;
         $display("FAIL break_drain: %0d events pending, required 0", q.size());
      end
   endtask

   task automatic test_ext();
      send_frame(8'hE0, 1'b0, 1'b1);
      push(K_MAKE, 8'h74, 1'b1);
      send_frame(8'h74, 1'b0, 1'b1);
      push(K_MAKE, 8'h6B, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b1);
      // extended release: E0 F0 74
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      push(K_REL, 8'h74, 1'b1);
      send_frame(8'h74, 1'b0, 1'b1);
      drain();
      checks++;
      if (q.size() !== 0) begin
         failures++;
         $display("FAIL ext_drain: %0d events pending, required 0", q.size());
      end
   endtask

   task automatic test_parity();
      push(K_ERR, exp_code, exp_ext);
      send_frame(8'h6B, 1'b1, 1'b1);
      push(K_MAKE, 8'h6B, 1'b0);
      send_frame(8'h6B, 1'b0, 1'b1);
      drain();
      checks++;
      if (q.size() !== 0) begin
         failures++;
         $display("FAIL parity_drain: %0d events pending, required 0", q.size());
      end
   endtask

   task automatic test_stop_err();
      // bad stop after E0 must clear the pending ext flag
      send_frame(8'hE0, 1'b0, 1'b1);
      push(K_ERR, exp_code, exp_ext);
      send_frame(8'h74, 1'b0, 1'b0);
      push(K_MAKE, 8'h74, 1'b0);
      send_frame(8'h74, 1'b0, 1'b1);
      drain();
      checks++;
      if (q.size() !== 0) begin
         failures++;
         $display("FAIL stop_drain: %0d events pending, required 0", q.size());
      end
   endtask

   task automatic test_timeout();
      push(K_ERR, exp_code, exp_ext);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (TO + 2) @(posedge iCLK);
      drain();
      push(K_MAKE, 8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1);
      drain();
      checks++;
      if (q.size() !== 0) begin
         failures++;
         $display("FAIL timeout_drain: %0d events pending, required 0", q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'hF0, 1'b0, 1'b1);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(i[0]);
      iRST_n = 1'b0;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge iCLK);
      checks++;
      if ({key_code, key_en, key_rel, key_ext, frame_err} !== 12'h000) begin
         failures++;
         $display("FAIL midreset_outputs: got %03h, required 000",
                  {key_code, key_en, key_rel, key_ext, frame_err});
      end
      iRST_n = 1'b1;
      repeat (5) @(posedge iCLK);
      push(K_MAKE, 8'h75, 1'b0);
      send_frame(8'h75, 1'b0, 1'b1);
      drain();
      checks++;
      if (q.size() !== 0) begin
         failures++;
         $display("FAIL midreset_drain: %0d events pending, required 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_make();
      test_break();
      test_ext();
      test_parity();
      test_stop_err();
      test_timeout();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
